// File: rtl/bullet_ram_scheduler.sv
// Shares the single-port BulletRAM between CPU and renderer frame scan; BULLET_SKIP_INACTIVE_EN drops inactive entries.
// Latency: frame_start -> first fetch_valid in 3 cycles; 3 cycles per presented entry when the port is otherwise idle.
// Backpressure: CPU never stalls; the scan waits in ISSUE on CPU cycles and holds each entry until fetch_ready.
module bullet_ram_scheduler #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 6,
  parameter int DEPTH         = 64,
  parameter int ACTIVE_BIT    = 31
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_wEn,
  input  logic                     cpu_readEn,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_dataIn,
  output logic [DATA_WIDTH-1:0]    cpu_dataOut,
  output logic                     ram_wEn,
  output logic                     ram_readEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_dataIn,
  input  logic [DATA_WIDTH-1:0]    ram_dataOut,
  input  logic                     frame_start,
  output logic                     fetch_valid,
  input  logic                     fetch_ready,
  output logic [ADDRESS_WIDTH-1:0] fetch_index,
  output logic [DATA_WIDTH-1:0]    fetch_data,
  output logic                     scan_busy,
  output logic                     scan_done,
  output logic                     overrun
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, PRESENT} scanState;

`ifdef BULLET_SKIP_INACTIVE_EN
  localparam bit SkipInactive = 1'b1;
`else
  localparam bit SkipInactive = 1'b0;
`endif

  scanState                 state;
  logic [ADDRESS_WIDTH-1:0] idx;
  logic                     cpuAccess;
  logic                     lastIdx;
  logic                     skipEntry;
  logic                     finishing;

  assign cpuAccess   = cpu_wEn | cpu_readEn;
  assign lastIdx     = (idx == ADDRESS_WIDTH'(DEPTH - 1));
  assign skipEntry   = SkipInactive && !ram_dataOut[ACTIVE_BIT];
  assign cpu_dataOut = ram_dataOut;

  // A scan finishes either on the last handshake or on skipping the last entry.
  assign finishing = ((state == PRESENT) && fetch_ready && lastIdx) ||
                     ((state == CAPTURE) && skipEntry && lastIdx);

  always_comb begin
    ram_wEn    = 1'b0;
    ram_readEn = 1'b0;
    ram_addr   = '0;
    ram_dataIn = '0;
    if (cpuAccess) begin
      ram_wEn    = cpu_wEn;
      ram_readEn = cpu_readEn;
      ram_addr   = cpu_addr;
      ram_dataIn = cpu_dataIn;
    end else if (state == ISSUE) begin
      ram_readEn = 1'b1;
      ram_addr   = idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      fetch_valid <= 1'b0;
      fetch_index <= '0;
      fetch_data  <= '0;
      scan_busy   <= 1'b0;
      scan_done   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (finishing) begin
        // A frame_start coinciding with completion is a clean back-to-back start, not an overrun.
        scan_done   <= 1'b1;
        fetch_valid <= 1'b0;
        idx         <= '0;
        state       <= frame_start ? ISSUE : IDLE;
        scan_busy   <= frame_start;
      end else if (frame_start && state != IDLE) begin
        state       <= ISSUE;
        idx         <= '0;
        fetch_valid <= 1'b0;
        overrun     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (frame_start) begin
              state     <= ISSUE;
              idx       <= '0;
              scan_busy <= 1'b1;
            end
          end
          ISSUE: begin
            if (!cpuAccess) state <= CAPTURE;
          end
          CAPTURE: begin
            if (skipEntry) begin
              idx   <= idx + ADDRESS_WIDTH'(1);
              state <= ISSUE;
            end else begin
              fetch_data  <= ram_dataOut;
              fetch_index <= idx;
              fetch_valid <= 1'b1;
              state       <= PRESENT;
            end
          end
          PRESENT: begin
            if (fetch_ready) begin
              fetch_valid <= 1'b0;
              idx         <= idx + ADDRESS_WIDTH'(1);
              state       <= ISSUE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bullet_ram_scheduler.sv
// Bench for bullet_ram_scheduler: behavioural BulletRAM, expected-beat and CPU-read scoreboards, directed scans.
module tb_bullet_ram_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_wEn = 1'b0;
  logic        cpu_readEn = 1'b0;
  logic [5:0]  cpu_addr = '0;
  logic [31:0] cpu_dataIn = '0;
  logic [31:0] cpu_dataOut;
  logic        ram_wEn;
  logic        ram_readEn;
  logic [5:0]  ram_addr;
  logic [31:0] ram_dataIn;
  logic [31:0] ram_dataOut;
  logic        frame_start = 1'b0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b1;
  logic [5:0]  fetch_index;
  logic [31:0] fetch_data;
  logic        scan_busy;
  logic        scan_done;
  logic        overrun;

  always #5 clock = ~clock;

  bullet_ram_scheduler dut (
    .clock(clock), .reset(reset),
    .cpu_wEn(cpu_wEn), .cpu_readEn(cpu_readEn), .cpu_addr(cpu_addr),
    .cpu_dataIn(cpu_dataIn), .cpu_dataOut(cpu_dataOut),
    .ram_wEn(ram_wEn), .ram_readEn(ram_readEn), .ram_addr(ram_addr),
    .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut),
    .frame_start(frame_start), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_index(fetch_index), .fetch_data(fetch_data),
    .scan_busy(scan_busy), .scan_done(scan_done), .overrun(overrun)
  );

  // Behavioural single-port RAM with registered read.
  logic [31:0] mem [64];
  logic [31:0] ramQ = '0;
  assign ram_dataOut = ramQ;
  always @(posedge clock) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    if (ram_readEn) ramQ <= mem[ram_addr];
  end

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model [64];
  logic [37:0] fetchQ [$];
  logic [31:0] rdQ [$];
  bit          scanEnd = 1'b0;
  bit          rdPend = 1'b0;
  bit          found;
  int          firstValid, doneCnt, doneAt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: CPU read data one cycle after readEn, fetch beats on handshake.
  initial begin
    forever begin
      @(negedge clock);
      if (rdPend) begin
        if (rdQ.size() == 0) check("cpu read expectation pending", 64'(rdQ.size()), 64'd1);
        else check("cpu_dataOut", 64'(cpu_dataOut), 64'(rdQ.pop_front()));
      end
      rdPend = cpu_readEn && !reset;
      if (fetch_valid && fetch_ready) begin
        if (fetchQ.size() == 0) check("fetch beat expectation pending", 64'(fetchQ.size()), 64'd1);
        else check("fetch beat {index,data}", 64'({fetch_index, fetch_data}), 64'(fetchQ.pop_front()));
      end
    end
  end

  task automatic preload(input bit sparse);
    for (int k = 0; k < 64; k++) begin
      logic [31:0] d;
      d = 32'(k);
      if (!sparse || k == 3 || k == 63) d[31] = 1'b1;
      cpu_wEn = 1'b1; cpu_addr = 6'(k); cpu_dataIn = d; model[k] = d;
      tick();
    end
    cpu_wEn = 1'b0;
  endtask

  task automatic pushScan(input int first, input int last);
    for (int k = first; k <= last; k++) fetchQ.push_back({6'(k), model[k]});
  endtask

  task automatic startFrame();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Cycle 1 is the cycle after the frame_start pulse; stops when scan_busy falls.
  task automatic runScan(input int budget);
    bit fin = 1'b0;
    firstValid = -1; doneCnt = 0; doneAt = -1; scanEnd = 1'b0;
    for (int c = 1; c <= budget && !fin; c++) begin
      @(negedge clock);
      if (fetch_valid && firstValid < 0) firstValid = c;
      if (scan_done) begin doneCnt++; doneAt = c; end
      if (!scan_busy) fin = 1'b1;
    end
    if (!fin) check("scan_busy fell within budget", 64'(scan_busy), 64'd0);
    scanEnd = 1'b1;
  endtask

  task automatic waitPresent(input int index, input int budget);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (fetch_valid && fetch_index == 6'(index)) found = 1'b1;
    end
    check($sformatf("entry %0d presented", index), 64'(found), 64'd1);
  endtask

  task automatic cpuTraffic();
    bit tog = 1'b1;
    int a = 1;
    while (!scanEnd) begin
      if (tog) begin
        cpu_readEn = 1'b1; cpu_addr = 6'(a); rdQ.push_back(model[a]);
        a = (a + 7) % 64;
      end else cpu_readEn = 1'b0;
      tog = !tog;
      tick();
    end
    cpu_readEn = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    @(negedge clock);
    check("reset fetch_valid", 64'(fetch_valid), 64'd0);
    check("reset scan_busy", 64'(scan_busy), 64'd0);
    check("reset scan_done", 64'(scan_done), 64'd0);
    check("reset overrun", 64'(overrun), 64'd0);
    check("reset fetch_index", 64'(fetch_index), 64'd0);
    check("reset fetch_data", 64'(fetch_data), 64'd0);
    check("reset ram ctrl {wEn,readEn,addr}", 64'({ram_wEn, ram_readEn, ram_addr}), 64'd0);
    check("reset ram_dataIn", 64'(ram_dataIn), 64'd0);
    tick();
    reset = 1'b0;

    // Full scan, no CPU traffic, renderer always ready.
    preload(1'b0);
    pushScan(0, 63);
    startFrame();
    runScan(400);
    check("t1 first valid cycle", 64'(firstValid), 64'd3);
    check("t1 scan_done cycle", 64'(doneAt), 64'd193);
    check("t1 scan_done count", 64'(doneCnt), 64'd1);
    @(negedge clock);
    check("t1 idle {busy,done,overrun}", 64'({scan_busy, scan_done, overrun}), 64'd0);
    check("t1 beats outstanding", 64'(fetchQ.size()), 64'd0);

    // CPU reads every other cycle during a scan.
    pushScan(0, 63);
    startFrame();
    fork
      runScan(600);
      cpuTraffic();
    join
    tick(); tick();
    check("t2 cpu reads outstanding", 64'(rdQ.size()), 64'd0);
    check("t2 beats outstanding", 64'(fetchQ.size()), 64'd0);
    check("t2 scan_done count", 64'(doneCnt), 64'd1);

    // Renderer stalls 10 cycles on entry 5 while the CPU rewrites it.
    pushScan(0, 63);
    startFrame();
    fork
      runScan(400);
      begin
        waitPresent(5, 100);
        fetch_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
          if (i == 0) begin
            cpu_wEn = 1'b1; cpu_addr = 6'd5; cpu_dataIn = 32'h8000_AA05; model[5] = 32'h8000_AA05;
          end else cpu_wEn = 1'b0;
          @(negedge clock);
          check("t3 held {valid,index,data}", 64'({fetch_valid, fetch_index, fetch_data}),
                64'({1'b1, 6'd5, 32'h8000_0005}));
          tick();
        end
        cpu_wEn = 1'b0;
        fetch_ready = 1'b1;
      end
    join
    check("t3 beats outstanding", 64'(fetchQ.size()), 64'd0);

    // frame_start lands mid-scan at entry 20; entry 5 now carries the rewritten value.
    pushScan(0, 19);
    pushScan(0, 63);
    startFrame();
    fork
      runScan(600);
      begin
        waitPresent(20, 200);
        fetch_ready = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        fetch_ready = 1'b1;
        @(negedge clock);
        check("t4 overrun after abort", 64'(overrun), 64'd1);
        check("t4 fetch_valid dropped", 64'(fetch_valid), 64'd0);
      end
    join
    check("t4 scan_done count", 64'(doneCnt), 64'd1);
    check("t4 overrun sticky", 64'(overrun), 64'd1);
    check("t4 beats outstanding", 64'(fetchQ.size()), 64'd0);

    // Reset while entry 10 is presented, then a clean restart.
    pushScan(0, 9);
    startFrame();
    waitPresent(10, 100);
    fetch_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fetch_ready = 1'b1;
    @(negedge clock);
    check("t5 post-reset {valid,busy,done,overrun}",
          64'({fetch_valid, scan_busy, scan_done, overrun}), 64'd0);
    check("t5 beats outstanding before restart", 64'(fetchQ.size()), 64'd0);
    pushScan(0, 63);
    startFrame();
    runScan(400);
    check("t5 restart first valid cycle", 64'(firstValid), 64'd3);
    check("t5 restart scan_done cycle", 64'(doneAt), 64'd193);
    check("t5 beats outstanding", 64'(fetchQ.size()), 64'd0);

    // frame_start on the final handshake chains a second scan without overrun.
    pushScan(0, 63);
    pushScan(0, 63);
    startFrame();
    fork
      runScan(800);
      begin
        waitPresent(63, 400);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
      end
    join
    check("t5b scan_done count", 64'(doneCnt), 64'd2);
    check("t5b overrun", 64'(overrun), 64'd0);
    check("t5b beats outstanding", 64'(fetchQ.size()), 64'd0);

    // Only entries 3 and 63 active.
    preload(1'b1);
`ifdef BULLET_SKIP_INACTIVE_EN
    pushScan(3, 3);
    pushScan(63, 63);
`else
    pushScan(0, 63);
`endif
    startFrame();
    runScan(400);
    check("t6 scan_done count", 64'(doneCnt), 64'd1);
`ifdef BULLET_SKIP_INACTIVE_EN
    check("t6 first valid cycle", 64'(firstValid), 64'd9);
    check("t6 scan_done cycle", 64'(doneAt), 64'd131);
`else
    check("t6 first valid cycle", 64'(firstValid), 64'd3);
    check("t6 scan_done cycle", 64'(doneAt), 64'd193);
`endif
    check("t6 beats outstanding", 64'(fetchQ.size()), 64'd0);

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
